// File: rtl/gpu_instr_queue.sv
// gpu_instr_queue: instruction FIFO between the AXI-lite instruction
// register and the GPU core cluster. Captures one word per rising edge of
// newInstruction and issues entries in order with a one-cycle execute strobe,
// then waits for the cores to drop coresReady (or for a timeout) before
// issuing again.
//
// Optional build macro: GPU_INSTR_ISSUE_COUNT_EN adds the issueCount
// (wrapping) and dropCount (saturating) statistics outputs.

module gpu_instr_queue #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = $clog2(DEPTH) + 1,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic              newInstruction,
    input  logic [DATA_W-1:0] instructionIn,
    input  logic              coresReady,
    output logic [DATA_W-1:0] instructionOut,
    output logic              sentInstruction,
    output logic [CNT_W-1:0]  bufferFill,
    output logic              overflow
`ifdef GPU_INSTR_ISSUE_COUNT_EN
    ,
    output logic [31:0]       issueCount,
    output logic [15:0]       dropCount
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMR_W = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [TMR_W-1:0]  timer, timer_n;
    logic              sent_n;
    logic              pop;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              nin_q;
    logic              push, full, empty, wr_en, drop;

    // A BVALID held high for many cycles must count as a single push
    assign push  = newInstruction & ~nin_q;
    assign full  = (bufferFill == CNT_FULL);
    assign empty = (bufferFill == '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    // Edge-detect register for the level-style newInstruction input
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) nin_q <= 1'b0;
        else                nin_q <= newInstruction;
    end

    // Storage array: no reset so it can map onto distributed RAM
    always_ff @(posedge S_AXI_ACLK) begin
        if (wr_en) mem[wr_ptr] <= instructionIn;
    end

    // Pointers, occupancy and sticky overflow flag
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            bufferFill <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   bufferFill <= bufferFill + CNT_W'(1);
                2'b01:   bufferFill <= bufferFill - CNT_W'(1);
                default: bufferFill <= bufferFill;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    // Issue FSM next-state logic; bufferFill is registered, so a word pushed
    // this cycle cannot be issued before the next one
    always_comb begin
        state_n = state;
        timer_n = timer;
        sent_n  = 1'b0;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (coresReady && !empty) begin
                    pop     = 1'b1;
                    sent_n  = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                timer_n = '0;
                state_n = WAIT;
            end
            WAIT: begin
                // Timeout catches cores that finish before ready visibly drops
                if (!coresReady || timer == TMR_LAST) state_n = IDLE;
                else                                  timer_n = timer + TMR_W'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    // Issue FSM state, timer and registered issue outputs
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state           <= IDLE;
            timer           <= '0;
            sentInstruction <= 1'b0;
            instructionOut  <= '0;
        end else begin
            state           <= state_n;
            timer           <= timer_n;
            sentInstruction <= sent_n;
            if (pop) instructionOut <= mem[rd_ptr];
        end
    end

`ifdef GPU_INSTR_ISSUE_COUNT_EN
    // Statistics: issues wrap freely, drops saturate
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            issueCount <= '0;
            dropCount  <= '0;
        end else begin
            if (pop) issueCount <= issueCount + 32'd1;
            if (drop && dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gpu_instr_queue.sv
// Self-checking bench for gpu_instr_queue: directed scenarios plus a
// randomized run compared against a queue-based reference model.

module tb_gpu_instr_queue;

    localparam int DATA_W      = 32;
    localparam int DEPTH       = 16;
    localparam int CNT_W       = 5;
    localparam int ACK_TIMEOUT = 8;

    logic              S_AXI_ACLK = 1'b0;
    logic              S_AXI_ARESETN = 1'b0;
    logic              newInstruction = 1'b0;
    logic [DATA_W-1:0] instructionIn = '0;
    logic              coresReady = 1'b0;
    logic [DATA_W-1:0] instructionOut;
    logic              sentInstruction;
    logic [CNT_W-1:0]  bufferFill;
    logic              overflow;
`ifdef GPU_INSTR_ISSUE_COUNT_EN
    logic [31:0]       issueCount;
    logic [15:0]       dropCount;
`endif

    gpu_instr_queue #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .S_AXI_ACLK     (S_AXI_ACLK),
        .S_AXI_ARESETN  (S_AXI_ARESETN),
        .newInstruction (newInstruction),
        .instructionIn  (instructionIn),
        .coresReady     (coresReady),
        .instructionOut (instructionOut),
        .sentInstruction(sentInstruction),
        .bufferFill     (bufferFill),
        .overflow       (overflow)
`ifdef GPU_INSTR_ISSUE_COUNT_EN
        ,
        .issueCount     (issueCount),
        .dropCount      (dropCount)
`endif
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a plain queue plus the edge number from which a new
    // issue is allowed again
    logic [DATA_W-1:0] mq[$];
    logic              m_nin;
    logic              m_ovf;
    logic [DATA_W-1:0] m_out;
    logic              m_sent;
    int                edge_n = 0;
    int                idle_from;
    bit                m_busy;
    int                issue_edge;
    int                m_issues;
    int                m_drops;

    // One clock: drive inputs, advance the model at the edge, settle 1 time unit
    task automatic tick(input logic nin, input logic [DATA_W-1:0] din, input logic rdy);
        bit pushed;
        newInstruction = nin;
        instructionIn  = din;
        coresReady     = rdy;
        @(posedge S_AXI_ACLK);
        edge_n++;
        // After an issue: one dead cycle, then free again once ready drops or
        // ACK_TIMEOUT cycles of waiting have elapsed
        if (m_busy && edge_n >= issue_edge + 2 &&
            (!rdy || edge_n == issue_edge + 1 + ACK_TIMEOUT)) begin
            m_busy    = 1'b0;
            idle_from = edge_n + 1;
        end
        pushed = nin && !m_nin;
        m_sent = 1'b0;
        if (!m_busy && edge_n >= idle_from && rdy && mq.size() != 0) begin
            m_out      = mq.pop_front();
            m_sent     = 1'b1;
            m_busy     = 1'b1;
            issue_edge = edge_n;
            m_issues++;
        end
        if (pushed) begin
            if (mq.size() < DEPTH) mq.push_back(din);
            else begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
        end
        m_nin = nin;
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_nin     = 1'b0;
        m_ovf     = 1'b0;
        m_out     = '0;
        m_sent    = 1'b0;
        m_busy    = 1'b0;
        idle_from = 0;
        m_issues  = 0;
        m_drops   = 0;
    endtask

    task automatic do_reset();
        newInstruction = 1'b0;
        coresReady     = 1'b0;
        S_AXI_ARESETN  = 1'b0;
        @(negedge S_AXI_ACLK);
        S_AXI_ARESETN  = 1'b1;
        model_reset();
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        tick(1'b1, w, 1'b0);
        tick(1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        newInstruction = 1'b0;
        coresReady     = 1'b1;
        S_AXI_ARESETN  = 1'b0;
        #3;
        n_cmp++; if (bufferFill !== '0)     begin n_err++; $display("FAIL reset_fill got=%0d exp=0", bufferFill); end
        n_cmp++; if (sentInstruction !== 0) begin n_err++; $display("FAIL reset_sent got=%b exp=0", sentInstruction); end
        n_cmp++; if (instructionOut !== '0) begin n_err++; $display("FAIL reset_out got=%h exp=0", instructionOut); end
        n_cmp++; if (overflow !== 0)        begin n_err++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
`ifdef GPU_INSTR_ISSUE_COUNT_EN
        n_cmp++; if (issueCount !== 0)      begin n_err++; $display("FAIL reset_icnt got=%0d exp=0", issueCount); end
        n_cmp++; if (dropCount !== 0)       begin n_err++; $display("FAIL reset_dcnt got=%0d exp=0", dropCount); end
`endif
        @(negedge S_AXI_ACLK);
        S_AXI_ARESETN = 1'b1;
        model_reset();
        begin
            int pulses = 0;
            for (int i = 0; i < 12; i++) begin
                tick(1'b0, '0, 1'b1);
                if (sentInstruction === 1'b1) pulses++;
            end
            n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL idle_no_pulse got=%0d exp=0", pulses); end
        end
    endtask

    task automatic test_held_push();
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 32'hA000_0001, 1'b0);
        tick(1'b0, '0, 1'b0);
        n_cmp++; if (bufferFill !== CNT_W'(1)) begin n_err++; $display("FAIL held_push_fill got=%0d exp=1", bufferFill); end
    endtask

    task automatic test_ordered_issue();
        logic [DATA_W-1:0] words [3];
        words[0] = 32'h1000_0001;
        words[1] = 32'h2000_0002;
        words[2] = 32'h3000_0003;
        do_reset();
        for (int i = 0; i < 3; i++) push_word(words[i]);
        n_cmp++; if (bufferFill !== CNT_W'(3)) begin n_err++; $display("FAIL ord_fill_start got=%0d exp=3", bufferFill); end
        for (int k = 0; k < 3; k++) begin
            bit seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                tick(1'b0, '0, 1'b1);
                if (sentInstruction === 1'b1) seen = 1'b1;
            end
            n_cmp++; if (!seen) begin n_err++; $display("FAIL ord_pulse_timeout k=%0d got=none exp=pulse", k); end
            n_cmp++; if (instructionOut !== words[k]) begin n_err++; $display("FAIL ord_word k=%0d got=%h exp=%h", k, instructionOut, words[k]); end
            n_cmp++; if (bufferFill !== CNT_W'(2 - k)) begin n_err++; $display("FAIL ord_fill k=%0d got=%0d exp=%0d", k, bufferFill, 2 - k); end
            tick(1'b0, '0, 1'b0);
            n_cmp++; if (sentInstruction !== 1'b0) begin n_err++; $display("FAIL ord_single_cycle k=%0d got=%b exp=0", k, sentInstruction); end
            n_cmp++; if (instructionOut !== words[k]) begin n_err++; $display("FAIL ord_hold k=%0d got=%h exp=%h", k, instructionOut, words[k]); end
            tick(1'b0, '0, 1'b0);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 17; i++) push_word(32'hC000_0000 + i);
        n_cmp++; if (bufferFill !== CNT_W'(16)) begin n_err++; $display("FAIL ovf_fill got=%0d exp=16", bufferFill); end
        n_cmp++; if (overflow !== 1'b1)         begin n_err++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        for (int i = 1; i <= 16; i++) begin
            bit seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                tick(1'b0, '0, 1'b1);
                if (sentInstruction === 1'b1) seen = 1'b1;
            end
            n_cmp++;
            if (!seen || instructionOut !== 32'hC000_0000 + i) begin
                n_err++; $display("FAIL ovf_drain i=%0d got=%h exp=%h seen=%b", i, instructionOut, 32'hC000_0000 + i, seen);
            end
            tick(1'b0, '0, 1'b0);
            tick(1'b0, '0, 1'b0);
        end
        begin
            int pulses = 0;
            for (int c = 0; c < 12; c++) begin
                tick(1'b0, '0, 1'b1);
                if (sentInstruction === 1'b1) pulses++;
            end
            n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL ovf_word17_lost got=%0d exp=0 extra pulses", pulses); end
        end
        n_cmp++; if (bufferFill !== '0)  begin n_err++; $display("FAIL ovf_empty got=%0d exp=0", bufferFill); end
        n_cmp++; if (overflow !== 1'b1)  begin n_err++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
`ifdef GPU_INSTR_ISSUE_COUNT_EN
        n_cmp++; if (dropCount !== 16'd1)  begin n_err++; $display("FAIL ovf_dcnt got=%0d exp=1", dropCount); end
        n_cmp++; if (issueCount !== 32'd16) begin n_err++; $display("FAIL ovf_icnt got=%0d exp=16", issueCount); end
`endif
    endtask

    task automatic test_timeout();
        int pe[$];
        do_reset();
        push_word(32'h5555_0001);
        push_word(32'h5555_0002);
        for (int c = 0; c < 30; c++) begin
            tick(1'b0, '0, 1'b1);
            if (sentInstruction === 1'b1) pe.push_back(edge_n);
        end
        n_cmp++; if (pe.size() != 2) begin n_err++; $display("FAIL tmo_count got=%0d exp=2", pe.size()); end
        else begin
            n_cmp++;
            if (pe[1] - pe[0] != 2 + ACK_TIMEOUT) begin
                n_err++; $display("FAIL tmo_spacing got=%0d exp=%0d", pe[1] - pe[0], 2 + ACK_TIMEOUT);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen = 1'b0;
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 4; i++) push_word(32'h7700_0000 + i);
        for (int c = 0; c < 20 && !seen; c++) begin
            tick(1'b0, '0, 1'b1);
            if (sentInstruction === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL rmw_first_pulse got=none exp=pulse"); end
`ifdef GPU_INSTR_ISSUE_COUNT_EN
        n_cmp++; if (issueCount !== 32'd1) begin n_err++; $display("FAIL rmw_icnt_pre got=%0d exp=1", issueCount); end
`endif
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1);
        // mid-cycle, asynchronous assertion
        S_AXI_ARESETN = 1'b0;
        #1;
        n_cmp++; if (bufferFill !== '0)       begin n_err++; $display("FAIL rmw_fill got=%0d exp=0", bufferFill); end
        n_cmp++; if (sentInstruction !== 1'b0) begin n_err++; $display("FAIL rmw_sent got=%b exp=0", sentInstruction); end
`ifdef GPU_INSTR_ISSUE_COUNT_EN
        n_cmp++; if (issueCount !== 32'd0)    begin n_err++; $display("FAIL rmw_icnt_rst got=%0d exp=0", issueCount); end
`endif
        @(negedge S_AXI_ACLK);
        S_AXI_ARESETN = 1'b1;
        model_reset();
        for (int c = 0; c < 15; c++) begin
            tick(1'b0, '0, 1'b1);
            if (sentInstruction === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL rmw_no_pulse got=%0d exp=0", pulses); end
`ifdef GPU_INSTR_ISSUE_COUNT_EN
        push_word(32'h7700_00FF);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick(1'b0, '0, 1'b1);
            if (sentInstruction === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (issueCount !== 32'd1 || !seen) begin n_err++; $display("FAIL rmw_icnt_post got=%0d exp=1", issueCount); end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            logic nin, rdy;
            int thr;
            // phases: mostly filling (overflow), balanced, mostly draining
            thr = (c < 300) ? 5 : (c < 800) ? 60 : 90;
            nin = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 99) < thr);
            tick(nin, $urandom, rdy);
            n_cmp++; if (bufferFill !== CNT_W'(mq.size())) begin n_err++; $display("FAIL rnd_fill cyc=%0d got=%0d exp=%0d", c, bufferFill, mq.size()); end
            n_cmp++; if (sentInstruction !== m_sent)       begin n_err++; $display("FAIL rnd_sent cyc=%0d got=%b exp=%b", c, sentInstruction, m_sent); end
            n_cmp++; if (instructionOut !== m_out)         begin n_err++; $display("FAIL rnd_out cyc=%0d got=%h exp=%h", c, instructionOut, m_out); end
            n_cmp++; if (overflow !== m_ovf)               begin n_err++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", c, overflow, m_ovf); end
`ifdef GPU_INSTR_ISSUE_COUNT_EN
            n_cmp++; if (issueCount !== 32'(m_issues))     begin n_err++; $display("FAIL rnd_icnt cyc=%0d got=%0d exp=%0d", c, issueCount, m_issues); end
            n_cmp++; if (dropCount !== 16'(m_drops))       begin n_err++; $display("FAIL rnd_dcnt cyc=%0d got=%0d exp=%0d", c, dropCount, m_drops); end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_held_push();
        test_ordered_issue();
        test_overflow();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpu_instr_queue.md
Name: gpu_instr_queue

Overview:
- Instruction FIFO between the AXI-lite instruction register (register 4) and the GPU core cluster (gpuLinker).
- Captures one 32-bit instruction per rising edge of the write-response valid signal and stores up to DEPTH entries.
- Issues entries in order to the cores, one per coresReady handshake, with a single-cycle execute pulse.
- Reports occupancy for readback through status register 3.

Parameters:
- DATA_W, 32, instruction width.
- DEPTH, 16, FIFO entries; power of two, 2..64.
- CNT_W, $clog2(DEPTH)+1, occupancy width (5 at default).
- ACK_TIMEOUT, 8, max cycles to wait for coresReady to drop after an issue.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESETN  in  1  reset; asynchronous assert, active-low.
- newInstruction  in  1  level signal (driven from BVALID); a push occurs on its 0->1 edge only.
- instructionIn  in  DATA_W  instruction word; sampled in the cycle the rising edge is detected.
- coresReady  in  1  cores idle and able to accept an instruction.
- instructionOut  out  DATA_W  last issued instruction; registered and held until the next issue.
- sentInstruction  out  1  one-cycle execute strobe; instructionOut is valid in the same cycle.
- bufferFill  out  CNT_W  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was dropped because the FIFO was full.

Behaviour:
- Reset (async, S_AXI_ARESETN=0): all outputs 0; read/write pointers 0; newInstruction edge register 0; FSM in IDLE. Storage contents are don't-care.
- Edge detect: push = newInstruction & ~nin_q, with nin_q registered. A BVALID held high for N cycles yields exactly one push.
- Push:
  - Writes instructionIn at wr_ptr, then wr_ptr++; pointers wrap modulo DEPTH.
  - When full with no pop in the same cycle: data dropped, pointers and count unchanged, overflow set to 1.
  - overflow clears only on reset.
- Pop: happens only on the IDLE->ISSUE transition.
- Push and pop in the same cycle: bufferFill unchanged. This is legal even when full, because the pop frees the slot.
- bufferFill: registered, incremented or decremented in the same edge as the pointer update. No wrap; held at DEPTH when full and 0 when empty.
- FSM IDLE:
  - Condition: coresReady=1 and bufferFill!=0.
  - Action: instructionOut<=mem[rd_ptr], rd_ptr++, sentInstruction<=1, go to ISSUE.
  - An entry pushed in cycle t is eligible for issue no earlier than t+1 (no fall-through).
- FSM ISSUE (1 cycle): sentInstruction<=0, timer<=0, go to WAIT.
- FSM WAIT:
  - Go to IDLE when coresReady=0, or when timer reaches ACK_TIMEOUT-1. The timeout covers cores that finish in fewer cycles than the ready drop takes to propagate.
  - Otherwise timer++.
- Issue spacing: consecutive sentInstruction pulses are at least 3 cycles apart.
- Issue latency: from coresReady=1 with a non-empty FIFO to the sentInstruction pulse is 1 cycle.
- Reset mid-operation: FSM, pointers and count return immediately to their reset values. No partial issue survives, so sentInstruction cannot stay high.
- The FIFO array needs no reset and may be inferred as distributed RAM.

Optional Feature:
- Macro: GPU_INSTR_ISSUE_COUNT_EN.
- When defined:
  - Adds output issueCount [31:0], a free-running count of sentInstruction pulses, reset to 0, wrapping 0xFFFFFFFF->0.
  - Adds output dropCount [15:0], a count of dropped pushes that saturates at 0xFFFF.
  - Both are intended for the spare status registers.
- When undefined: neither port nor counter exists, and all other behaviour is identical.

Test Plan:
- Reset then idle: bufferFill=0, sentInstruction=0, instructionOut=0, overflow=0. coresReady=1 produces no pulse.
- Held-level push: newInstruction high for 5 cycles with instructionIn=0xA0000001 and coresReady=0 -> bufferFill=1, not 5.
- Ordered issue: push 0x10000001, 0x20000002, 0x30000003; pulse coresReady low for 1 cycle after each issue -> instructionOut shows the three words in order, three single-cycle pulses, bufferFill 3->0.
- Full and overflow: push 17 words with coresReady=0 -> bufferFill=16, overflow=1, 17th word lost. Drain -> words 1..16 in order.
- Timeout path: coresReady held at 1 with 2 entries -> pulses exactly 1+1+ACK_TIMEOUT=10 cycles apart.
- Reset mid-WAIT with 4 entries: assert S_AXI_ARESETN=0 for 1 cycle -> bufferFill=0 asynchronously and no further pulses. With GPU_INSTR_ISSUE_COUNT_EN defined, issueCount=0 after reset and increments once per pulse afterwards.
